// File: rtl/ps2_mouse_byte_receiver_pkg.sv
// Shared encodings for the PS/2 mouse byte receiver and the mouse master.
// Error codes are reused by the master when deciding whether to re-initialise.
package ps2_mouse_byte_receiver_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        STOP,
        DONE
    } state_t;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_PARITY = 2'b01;
    localparam logic [1:0] ERR_STOP   = 2'b10;

    localparam int TIMEOUT_CYCLES_DEFAULT = 5000;
    localparam int FILTER_CYCLES_DEFAULT  = 8;

    // Odd parity over data+parity must come out as 1; the stop bit must be 1.
    function automatic logic [1:0] frame_error(
        input logic [7:0] d,
        input logic       p,
        input logic       s
    );
        logic [1:0] e;
        e = ERR_NONE;
        if (^{d, p} != 1'b1) e = e | ERR_PARITY;
        if (s != 1'b1)       e = e | ERR_STOP;
        return e;
    endfunction

endpackage

// File: rtl/ps2_mouse_byte_receiver_if.sv
// Byte delivery bundle between the PS/2 receiver (master) and the mouse
// master state machine (slave).
interface ps2_mouse_byte_receiver_if;

    logic [7:0] BYTE_READ;
    logic [1:0] BYTE_ERROR_CODE;
    logic       BYTE_READY;
    logic       READ_ENABLE;

    modport master (
        output BYTE_READ,
        output BYTE_ERROR_CODE,
        output BYTE_READY,
        input  READ_ENABLE
    );

    modport slave (
        input  BYTE_READ,
        input  BYTE_ERROR_CODE,
        input  BYTE_READY,
        output READ_ENABLE
    );

endinterface

// File: rtl/ps2_mouse_byte_receiver_line_conditioner.sv
// PS/2 line synchroniser and falling-edge detector, shared with the transmitter.
// Optional clock glitch filter enabled by PS2_RX_GLITCH_FILTER_EN.
module ps2_line_conditioner
`ifdef PS2_RX_GLITCH_FILTER_EN
#(
    parameter int FILTER_CYCLES = 8
)
`endif
(
    input  logic clk,
    input  logic reset,
    input  logic clk_line,
    input  logic data_line,
    output logic fall,
    output logic data
);

    logic [1:0] clk_sync;
    logic [1:0] data_sync;
    logic       lvl;
    logic       lvl_q;

    // Flops reset to the idle-high line level so reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], clk_line};
            data_sync <= {data_sync[0], data_line};
        end
    end

`ifdef PS2_RX_GLITCH_FILTER_EN
    localparam int CW = $clog2(FILTER_CYCLES + 1);

    logic [CW-1:0] cnt;
    logic          filt;

    always_ff @(posedge clk) begin
        if (reset) begin
            filt <= 1'b1;
            cnt  <= '0;
        end else if (clk_sync[1] == filt) begin
            cnt <= '0;
        end else if (cnt == CW'(FILTER_CYCLES - 1)) begin
            filt <= clk_sync[1];
            cnt  <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign lvl = filt;
`else
    assign lvl = clk_sync[1];
`endif

    always_ff @(posedge clk) begin
        if (reset) lvl_q <= 1'b1;
        else       lvl_q <= lvl;
    end

    assign fall = lvl_q & ~lvl;
    assign data = data_sync[1];

endmodule

// File: rtl/ps2_mouse_byte_receiver.sv
// Device-to-host PS/2 frame deserialiser feeding the mouse master.
// Build option PS2_RX_GLITCH_FILTER_EN adds a clock glitch filter.
module ps2_mouse_byte_receiver
    import ps2_mouse_byte_receiver_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
`ifdef PS2_RX_GLITCH_FILTER_EN
  , parameter int FILTER_CYCLES  = FILTER_CYCLES_DEFAULT
`endif
)
(
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       CLK_MOUSE_IN,
    input  logic                       DATA_MOUSE_IN,
    ps2_mouse_byte_receiver_if.master  bus
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          fall;
    logic          data;
    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par;
    logic [TW-1:0] tmo;
    logic          in_frame;

`ifdef PS2_RX_GLITCH_FILTER_EN
    ps2_line_conditioner #(
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_cond (
`else
    ps2_line_conditioner u_cond (
`endif
        .clk       (CLK),
        .reset     (RESET),
        .clk_line  (CLK_MOUSE_IN),
        .data_line (DATA_MOUSE_IN),
        .fall      (fall),
        .data      (data)
    );

    assign in_frame = (state == DATA) || (state == PARITY) || (state == STOP);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state               <= IDLE;
            bit_cnt             <= '0;
            shift               <= '0;
            par                 <= 1'b0;
            tmo                 <= '0;
            bus.BYTE_READ       <= 8'h00;
            bus.BYTE_ERROR_CODE <= ERR_NONE;
            bus.BYTE_READY      <= 1'b0;
        end else begin
            bus.BYTE_READY <= 1'b0;

            if (in_frame && !fall) tmo <= tmo + 1'b1;
            else                   tmo <= '0;

            unique case (state)
                IDLE: begin
                    if (fall && bus.READ_ENABLE && !data) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (fall) begin
                        shift[bit_cnt] <= data;
                        bit_cnt        <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= PARITY;
                    end
                end
                PARITY: begin
                    if (fall) begin
                        par   <= data;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (fall) begin
                        bus.BYTE_READ       <= shift;
                        bus.BYTE_ERROR_CODE <= frame_error(shift, par, data);
                        bus.BYTE_READY      <= 1'b1;
                        state               <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Stalled frame: drop it silently, outputs keep the last byte.
            if (in_frame && !fall && tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                state <= IDLE;
                tmo   <= '0;
            end
        end
    end

endmodule
